// File: rtl/sp_ram_pkg.sv
// Shared types and RAM timing-control defaults for the single-port SRAM initiator.
package sp_ram_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Timing-control defaults per macro family
  localparam int          TSMC16_CTRL_W   = 4;
  localparam int          ARM_CTRL_W      = 6;
  localparam logic [3:0]  TSMC16_RAM_CTRL = 4'h0;
  localparam logic [5:0]  ARM_RAM_CTRL    = 6'h0;

endpackage

// File: rtl/sp_ram_initiator_if.sv
// Core/bus side req/gnt/rvalid port of the SRAM initiator.
interface sp_ram_initiator_if #(
  parameter int DW = 32,
  parameter int AW = 10
);
  logic          req;
  logic          gnt;
  logic [AW-1:0] addr;
  logic          we;
  logic [DW/8-1:0] be;
  logic [DW-1:0] wdata;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/sp_ram_clear_seq.sv
// Address counter for the clear sequencer; flags the final (all-ones) address.
module sp_ram_clear_seq #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [AW-1:0] addr,
  output logic          last
);

  logic [AW-1:0] cnt;

  // Held at zero outside a sequence so every run starts at address 0
  always_ff @(posedge clk) begin
    if (rst)     cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
    else         cnt <= '0;
  end

  assign addr = cnt;
  assign last = en & (cnt == '1);

endmodule

// File: rtl/sp_ram_initiator.sv
// Requester-side SRAM controller: bus-to-strobe mux, response regs and clear FSM.
//   state | meaning
//   IDLE  | serve bus requests, one grant per cycle
//   CLEAR | write INIT_VALUE to every word, bus not granted
module sp_ram_initiator
  import sp_ram_pkg::*;
#(
  parameter int              DW             = 32,
  parameter int              AW             = 10,
  parameter int              CTRL_W         = 6,
  parameter logic [CTRL_W-1:0] RAM_CTRL     = '0,
  parameter logic [DW-1:0]   INIT_VALUE     = '0,
  parameter bit              CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_start_i,
  output logic              init_busy_o,
  output logic              init_done_o,
  sp_ram_initiator_if.slave bus,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [DW/8-1:0]   ram_be_o,
  output logic [AW-1:0]     ram_addr_o,
  output logic [DW-1:0]     ram_wdata_o,
  input  logic [DW-1:0]     ram_rdata_i,
  output logic [CTRL_W-1:0] ram_ctrl_o
);

  state_t        state;
  logic          clr_en;
  logic          clr_last;
  logic [AW-1:0] clr_addr;
  logic          gnt;
  logic          rvalid_q;
  logic          rd_q;
  logic [DW-1:0] rdata_hold;

  assign clr_en = (state == CLEAR) & ~rst;
  assign gnt    = ~rst & (state == IDLE) & bus.req & ~init_start_i;

  sp_ram_clear_seq #(.AW(AW)) u_clear_seq (
    .clk  (clk),
    .rst  (rst),
    .en   (clr_en),
    .addr (clr_addr),
    .last (clr_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CLEAR_ON_RESET ? CLEAR : IDLE;
      init_done_o <= 1'b0;
    end else begin
      case (state)
        IDLE:  if (init_start_i) state <= CLEAR;
        CLEAR: if (clr_last) begin
          state       <= IDLE;
          init_done_o <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_be_o    = '1;
    ram_addr_o  = bus.addr;
    ram_wdata_o = bus.wdata;
    if (clr_en) begin
      ram_en_o    = 1'b1;
      ram_we_o    = 1'b1;
      ram_addr_o  = clr_addr;
      ram_wdata_o = INIT_VALUE;
    end else if (gnt) begin
      ram_en_o = 1'b1;
      ram_we_o = bus.we;
      ram_be_o = bus.we ? bus.be : '1;
    end
  end

  // Read data passes straight through in the response cycle, then is held
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q   <= 1'b0;
      rd_q       <= 1'b0;
      rdata_hold <= '0;
    end else begin
      rvalid_q <= gnt;
      rd_q     <= gnt & ~bus.we;
      if (rd_q) rdata_hold <= ram_rdata_i;
    end
  end

  assign bus.gnt     = gnt;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rd_q ? ram_rdata_i : rdata_hold;
  assign init_busy_o = (state == CLEAR);
  assign ram_ctrl_o  = RAM_CTRL;

endmodule

// File: tb/tb_sp_ram_initiator.sv
// Directed bench for sp_ram_initiator with a response scoreboard and SRAM model.
module tb_sp_ram_initiator;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int DEPTH = 1 << AW;
  localparam logic [5:0]  CTRL = 6'h2A;
  localparam logic [31:0] INIT = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init_start = 1'b0;
  logic init_busy, init_done;
  logic ram_en, ram_we;
  logic [3:0]  ram_be;
  logic [AW-1:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [5:0]  ram_ctrl;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    logic        rd;
    logic [31:0] data;
  } exp_t;
  exp_t sbq[$];

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] ram_mem [DEPTH];

  sp_ram_initiator_if #(.DW(DW), .AW(AW)) bif ();

  sp_ram_initiator #(
    .DW(DW), .AW(AW), .CTRL_W(6), .RAM_CTRL(CTRL),
    .INIT_VALUE(INIT), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .init_start_i (init_start),
    .init_busy_o  (init_busy),
    .init_done_o  (init_done),
    .bus          (bif),
    .ram_en_o     (ram_en),
    .ram_we_o     (ram_we),
    .ram_be_o     (ram_be),
    .ram_addr_o   (ram_addr),
    .ram_wdata_o  (ram_wdata),
    .ram_rdata_i  (ram_rdata),
    .ram_ctrl_o   (ram_ctrl)
  );

  always #5 clk = ~clk;

  // SRAM wrapper model: byte-enabled write, registered read
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_be[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_rdata <= ram_mem[ram_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every grant expects rvalid next cycle; reads carry expected data
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
      e = sbq.pop_front();
      chk("rvalid_resp", {31'b0, bif.rvalid}, 32'h1);
      if (e.rd) chk("rdata_resp", bif.rdata, e.data);
    end else begin
      chk("rvalid_idle", {31'b0, bif.rvalid}, 32'h0);
    end
    if (bif.gnt === 1'b1) begin
      e.cyc  = cyc + 1;
      e.rd   = ~bif.we;
      e.data = ref_mem[bif.addr];
      sbq.push_back(e);
      if (bif.we)
        for (int b = 0; b < 4; b++)
          if (bif.be[b]) ref_mem[bif.addr][8*b +: 8] = bif.wdata[8*b +: 8];
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic ref_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = INIT;
  endtask

  // Entered in the first CLEAR cycle (counter 0); pulse_at < 0 means no stray start
  task automatic check_clear(input int pulse_at, input logic done_before);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      chk("clr_en",    {31'b0, ram_en}, 32'h1);
      chk("clr_we",    {31'b0, ram_we}, 32'h1);
      chk("clr_be",    {28'b0, ram_be}, 32'hF);
      chk("clr_addr",  {28'b0, ram_addr}, i);
      chk("clr_wdata", ram_wdata, INIT);
      chk("clr_gnt",   {31'b0, bif.gnt}, 32'h0);
      chk("clr_busy",  {31'b0, init_busy}, 32'h1);
      chk("clr_done",  {31'b0, init_done}, {31'b0, done_before});
      next_cycle();
      init_start = (i + 1 == pulse_at);
    end
    init_start = 1'b0;
    @(negedge clk);
    chk("clr_end_busy", {31'b0, init_busy}, 32'h0);
    chk("clr_end_done", {31'b0, init_done}, 32'h1);
    chk("clr_end_gnt",  {31'b0, bif.gnt}, {31'b0, bif.req});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ref_clear();
    bif.req = 1'b1; bif.we = 1'b1; bif.addr = '0; bif.be = 4'hF; bif.wdata = 32'hFFFF_FFFF;
    repeat (3) next_cycle();
    @(negedge clk);
    chk("rst_gnt",    {31'b0, bif.gnt}, 32'h0);
    chk("rst_en",     {31'b0, ram_en}, 32'h0);
    chk("rst_we",     {31'b0, ram_we}, 32'h0);
    chk("rst_done",   {31'b0, init_done}, 32'h0);
    chk("rst_rdata",  bif.rdata, 32'h0);
    chk("ram_ctrl",   {26'b0, ram_ctrl}, {26'b0, CTRL});
    next_cycle();
    bif.req = 1'b0;
    rst = 1'b0;
    check_clear(-1, 1'b0);

    // Partial write then read-back
    next_cycle();
    bif.req = 1'b1; bif.we = 1'b1; bif.addr = 4'd5; bif.be = 4'b0011; bif.wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("wr_gnt",  {31'b0, bif.gnt}, 32'h1);
    chk("wr_we",   {31'b0, ram_we}, 32'h1);
    chk("wr_be",   {28'b0, ram_be}, 32'h3);
    chk("wr_addr", {28'b0, ram_addr}, 32'd5);
    next_cycle();
    bif.we = 1'b0; bif.be = 4'h0;
    @(negedge clk);
    chk("rd_gnt", {31'b0, bif.gnt}, 32'h1);
    chk("rd_be",  {28'b0, ram_be}, 32'hF);
    next_cycle();
    bif.req = 1'b0;
    @(negedge clk);
    chk("rd5_data", bif.rdata, 32'h0000BEEF);

    // Back-to-back writes then reads at 1..3
    for (int k = 1; k <= 3; k++) begin
      next_cycle();
      bif.req = 1'b1; bif.we = 1'b1; bif.addr = AW'(k); bif.be = 4'hF;
      bif.wdata = 32'hA5000000 | k * 32'h00010101;
    end
    for (int k = 1; k <= 3; k++) begin
      next_cycle();
      bif.we = 1'b0; bif.addr = AW'(k);
      @(negedge clk);
      chk("b2b_gnt", {31'b0, bif.gnt}, 32'h1);
    end
    next_cycle();
    bif.req = 1'b0;
    repeat (2) @(negedge clk);
    chk("hold_rdata", bif.rdata, 32'hA5030303);
    next_cycle();
    bif.req = 1'b1; bif.we = 1'b1; bif.addr = 4'd7; bif.wdata = 32'h0BAD_F00D;
    next_cycle();
    bif.req = 1'b0;
    repeat (2) @(negedge clk);
    chk("wr_keeps_rdata", bif.rdata, 32'hA5030303);

    // Read just before clear, then start with req held high
    next_cycle();
    bif.req = 1'b1; bif.we = 1'b0; bif.addr = 4'd5;
    next_cycle();
    bif.addr = 4'd2; init_start = 1'b1;
    @(negedge clk);
    chk("start_gnt", {31'b0, bif.gnt}, 32'h0);
    chk("start_en",  {31'b0, ram_en}, 32'h0);
    next_cycle();
    init_start = 1'b0;
    ref_clear();
    check_clear(-1, 1'b1);
    next_cycle();
    bif.req = 1'b0;

    // Reset with the counter at 7
    init_start = 1'b1;
    next_cycle();
    init_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("pre_rst_addr", {28'b0, ram_addr}, i);
      next_cycle();
    end
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_en", {31'b0, ram_en}, 32'h0);
    chk("mid_rst_we", {31'b0, ram_we}, 32'h0);
    next_cycle();
    @(negedge clk);
    chk("mid_rst_done", {31'b0, init_done}, 32'h0);
    next_cycle();
    rst = 1'b0;
    check_clear(-1, 1'b0);

    // Stray start during clear is ignored
    next_cycle();
    init_start = 1'b1;
    next_cycle();
    init_start = 1'b0;
    check_clear(5, 1'b1);

    repeat (3) next_cycle();
    chk("sb_empty", sbq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
